sr_latch_checker: RTL

Clocked self-checking monitor for the NAND-type SR latch (active-low S and R). It observes the latch inputs and outputs and maintains a reference model of the latch state. After each input change and a programmable settle time, it compares the latch outputs against the model. It counts mismatches and flags forbidden-input intervals, so benches and on-board debug logic can verify the latch without manual waveform inspection.

---
 rtl/sr_latch_checker_if.sv | 25 ++
 rtl/sr_latch_checker.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sr_latch_checker_if.sv
// Observation bundle between an SR latch under test and its checker.
// master drives the latch pins; slave is the checker that reports verdicts.
interface sr_latch_checker_if #(
   parameter int CNT_W = 8
);
   logic             S;
   logic             R;
   logic             Q;
   logic             Qn;
   logic             err;
   logic [CNT_W-1:0] err_cnt;
   logic             forbid;
   logic             known;
   logic             exp_q;

   modport master (
      output S, R, Q, Qn,
      input  err, err_cnt, forbid, known, exp_q
   );

   modport slave (
      input  S, R, Q, Qn,
      output err, err_cnt, forbid, known, exp_q
   );
endinterface

// File: rtl/sr_latch_checker.sv
// Clocked monitor for a NAND SR latch: tracks a reference model and checks Q/Qn after settling.
// Optional macro SR_CHK_FORBID_ERR_EN also counts each entry into S=R=0 as an error.
module sr_latch_checker #(
   parameter int SETTLE_CYC = 3,
   parameter int CNT_W      = 8
) (
   input logic               clk,
   input logic               rst_n,
   sr_latch_checker_if.slave bus
);

   localparam logic [1:0] ST_UNK    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;
   localparam logic [3:0] LOAD      = 4'(SETTLE_CYC - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic             s_d, r_d, q_d, qn_d;
   logic [1:0]       sr_prev;
   logic             primed_p0, primed_p1;
   logic [1:0]       state, state_nx;
   logic [3:0]       cnt, cnt_nx;
   logic             err_r, err_nx;
   logic [CNT_W-1:0] err_cnt_r;
   logic             forbid_r, forbid_nx;
   logic             known_r, known_nx;
   logic             exp_q_r, exp_q_nx;
   logic [1:0]       sr;
   logic             chg, mism, check_fail;

   // Sample registers hold reset values for one cycle after release, so decisions
   // wait for primed_p0 and change detection waits for a valid sr_prev (primed_p1).
   assign sr  = {s_d, r_d};
   assign chg = primed_p1 && (sr != sr_prev);
   assign mism = (sr == 2'b00) ? !(q_d && qn_d)
                               : ((q_d != exp_q_r) || (qn_d != !exp_q_r));

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      check_fail = 1'b0;
      if (primed_p0) begin
         case (state)
            ST_UNK: begin
               if (sr != 2'b11) begin
                  state_nx = ST_SETTLE;
                  cnt_nx   = LOAD;
               end
            end
            ST_SETTLE: begin
               if (chg) begin
                  cnt_nx = LOAD;
               end else if (cnt <= 4'd1) begin
                  cnt_nx   = 4'd0;
                  state_nx = (known_r || (sr == 2'b00)) ? ST_CHECK : ST_UNK;
               end else begin
                  cnt_nx = cnt - 4'd1;
               end
            end
            ST_CHECK: begin
               // An input change takes priority over a coincident mismatch.
               if (chg) begin
                  state_nx = ST_SETTLE;
                  cnt_nx   = LOAD;
               end else begin
                  check_fail = mism;
               end
            end
            default: state_nx = ST_UNK;
         endcase
      end
   end

   always_comb begin
      known_nx  = known_r;
      exp_q_nx  = exp_q_r;
      forbid_nx = primed_p0 && (sr == 2'b00);
      if (primed_p0) begin
         if (sr == 2'b01) begin
            known_nx = 1'b1;
            exp_q_nx = 1'b1;
         end else if (sr == 2'b10) begin
            known_nx = 1'b1;
            exp_q_nx = 1'b0;
         end else if (chg && (sr_prev == 2'b00) && (sr == 2'b11)) begin
            known_nx = 1'b0;
         end
      end
   end

`ifdef SR_CHK_FORBID_ERR_EN
   assign err_nx = check_fail || (chg && (sr == 2'b00));
`else
   assign err_nx = check_fail;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d       <= 1'b0;
         r_d       <= 1'b0;
         q_d       <= 1'b0;
         qn_d      <= 1'b0;
         sr_prev   <= 2'b00;
         primed_p0 <= 1'b0;
         primed_p1 <= 1'b0;
         state     <= ST_UNK;
         cnt       <= 4'd0;
         err_r     <= 1'b0;
         err_cnt_r <= '0;
         forbid_r  <= 1'b0;
         known_r   <= 1'b0;
         exp_q_r   <= 1'b0;
      end else begin
         s_d       <= bus.S;
         r_d       <= bus.R;
         q_d       <= bus.Q;
         qn_d      <= bus.Qn;
         sr_prev   <= sr;
         primed_p0 <= 1'b1;
         primed_p1 <= primed_p0;
         state     <= state_nx;
         cnt       <= cnt_nx;
         err_r     <= err_nx;
         if (err_nx) err_cnt_r <= sat_inc(err_cnt_r);
         forbid_r  <= forbid_nx;
         known_r   <= known_nx;
         exp_q_r   <= exp_q_nx;
      end
   end

   assign bus.err     = err_r;
   assign bus.err_cnt = err_cnt_r;
   assign bus.forbid  = forbid_r;
   assign bus.known   = known_r;
   assign bus.exp_q   = exp_q_r;

endmodule
